pdm_mic_frontend: RTL
=====================

// Module: pdm_mic_frontend
// PURPOSE
//   Front end feeding the 16-mic delay-and-sum beamformer core. Drives one shared PDM clock to 8
//   stereo PDM microphone pairs (L/R on opposite edges = 16 channels), decimates each 1-bit
//   stream with a first-order boxcar (CIC-1) over DECIM PDM periods, and streams one signed PCM
//   sample per channel per frame to the beamformer over a valid/ready interface.
// PARAMETERS
//   CLK_DIV  8   clk cycles per pdm_clk period; even, >= 4
//   DECIM    64  PDM periods per output frame; power of 2, >= 4
//   (localparam) OUT_W = $clog2(DECIM)+1  PCM sample width (7 at default)
// PORTS
//   clk       in   1      system clock
//   rst       in   1      synchronous reset, active-high
//   en        in   1      capture enable
//   pdm_clk   out  1      microphone clock
//   pdm_data  in   8      pin i carries channel 2i (L) and 2i+1 (R)
//   s_valid   out  1      PCM sample valid
//   s_ready   in   1      downstream accepts sample
//   s_data    out  OUT_W  signed PCM sample, two's complement
//   s_chan    out  4      channel index of s_data
//   s_last    out  1      high with channel 15 (end of frame)
//   overflow  out  1      sticky: a frame was dropped
// BEHAVIOUR
//   Reset: all outputs 0; divider, pair counter, accumulators, buffer cleared; nothing pending.
//   Divider: div counts 0..CLK_DIV-1 while en=1; pdm_clk=1 for div<CLK_DIV/2, else 0 (registered).
//   en=0: div, pair counter, accumulators held at 0, pdm_clk=0; a stream already in progress
//     still completes. en 0->1 starts a fresh frame; first frame is emitted normally.
//   Sampling (only when en=1): at div==CLK_DIV/2-1 add pdm_data[i] to acc[2i+1];
//     at div==CLK_DIV-1 add pdm_data[i] to acc[2i]. Accumulators are $clog2(DECIM)+1 bits, range 0..DECIM.
//   Pair counter increments at each div==CLK_DIV-1 sample. Frame closes on that sample when
//     pair counter==DECIM-1: all 16 results (including this cycle's bits) go to the output
//     buffer, accumulators and pair counter clear in the same cycle. Frame = CLK_DIV*DECIM clks.
//   Conversion: sample = acc - DECIM/2 (signed OUT_W). All ones -> +DECIM/2, all zeros -> -DECIM/2.
//   Output buffer: 16 entries + pending flag. On frame close with buffer empty: load, pending=1;
//     s_valid rises the next cycle with s_chan=0.
//   Stream: one channel per accepted beat, s_chan 0..15 ascending; transfer when s_valid&&s_ready.
//     While s_valid&&!s_ready, s_data/s_chan/s_last hold stable. After channel 15 accepted:
//     s_valid=0 next cycle, buffer empty. Back-to-back beats at 1/clk with s_ready=1 (16 cycles).
//   Overflow: frame close while buffer still pending -> new frame discarded, buffered frame and
//     stream untouched, overflow=1 until rst. Frame close on the same cycle channel 15 is
//     accepted counts as empty: new frame loads, s_valid stays high, s_chan wraps to 0, no overflow.
//   Reset mid-stream or mid-frame: everything returns to reset state next cycle; partial data lost.
// TESTING
//   pdm_data=8'hFF, en=1, s_ready=1 -> first s_valid 1 cycle after clk 512 (defaults); 16 beats,
//     s_chan 0..15, s_data=+32 each, s_last only on chan 15; repeats every 512 clks.
//   pdm_data=8'h00 -> all 16 channels -32; pdm_clk period 8 clks, high 4 clks, low when en=0.
//   pdm_data=pdm_clk?8'hFF:8'h00 -> odd channels +32, even channels -32 (edge/channel mapping).
//   pin 3 only toggles per PDM period (1,0,1,0..) -> chan 6 and 7 = 0, all others -32.
//   s_ready=0 for 1100 clks -> chan 0 held stable, frames 2 and 3 dropped, overflow=1; release
//     -> frame 1 emitted intact, then frame 4 normally, overflow stays 1.
//   rst pulse at beat chan 5 -> s_valid=0, overflow=0 next cycle; next frame full 512 clks later.

Source files
------------

// File: rtl/pdm_mic_frontend.sv
// PDM front end for the 16-mic beamformer: shared PDM clock, boxcar decimation of 16 channels,
// and a buffered valid/ready PCM stream, one frame of 16 samples at a time.
//
// state     | meaning
// ST_IDLE   | output buffer empty, waiting for a frame to close
// ST_STREAM | buffer pending, presenting channel rd_idx to the beamformer
module pdm_mic_frontend #(
  parameter int CLK_DIV = 8,
  parameter int DECIM   = 64,
  localparam int OUT_W  = $clog2(DECIM) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic                    pdm_clk,
  input  logic [7:0]              pdm_data,
  output logic                    s_valid,
  input  logic                    s_ready,
  output logic signed [OUT_W-1:0] s_data,
  output logic [3:0]              s_chan,
  output logic                    s_last,
  output logic                    overflow
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int PAIR_W = $clog2(DECIM);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_MID   = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(DECIM - 1);
  localparam logic [OUT_W-1:0]  MID_SCALE = OUT_W'(DECIM / 2);

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t                  state, state_nxt;
  logic [DIV_W-1:0]        div, div_nxt;
  logic [PAIR_W-1:0]       pair;
  logic [OUT_W-1:0]        acc     [16];
  logic [OUT_W-1:0]        acc_fin [16];
  logic signed [OUT_W-1:0] obuf    [16];
  logic [3:0]              rd_idx;
  logic                    pdm_clk_q;
  logic                    ovf_q;
  logic                    tick_mid, tick_end, close;
  logic                    fire, last_fire, load;

  always_comb begin
    tick_mid = en && (div == DIV_MID);
    tick_end = en && (div == DIV_LAST);
    close    = tick_end && (pair == PAIR_LAST);
    div_nxt  = '0;
    if (en && (div != DIV_LAST)) div_nxt = div + 1'b1;
  end

  // Final counts for a closing frame must include the left bits sampled this very cycle.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      acc_fin[2*i]   = acc[2*i] + OUT_W'(pdm_data[i]);
      acc_fin[2*i+1] = acc[2*i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      pair      <= '0;
      pdm_clk_q <= 1'b0;
      for (int c = 0; c < 16; c++) acc[c] <= '0;
    end else begin
      div       <= div_nxt;
      pdm_clk_q <= en && (div_nxt < DIV_HALF);
      if (!en) begin
        pair <= '0;
        for (int c = 0; c < 16; c++) acc[c] <= '0;
      end else if (tick_mid) begin
        for (int i = 0; i < 8; i++) acc[2*i+1] <= acc[2*i+1] + OUT_W'(pdm_data[i]);
      end else if (tick_end) begin
        if (close) begin
          pair <= '0;
          for (int c = 0; c < 16; c++) acc[c] <= '0;
        end else begin
          pair <= pair + 1'b1;
          for (int i = 0; i < 8; i++) acc[2*i] <= acc_fin[2*i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A frame closing on the same cycle channel 15 is taken sees an empty buffer.
  always_comb begin
    state_nxt = state;
    s_valid   = 1'b0;
    fire      = 1'b0;
    last_fire = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        load = close;
        if (close) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        s_valid   = 1'b1;
        fire      = s_ready;
        last_fire = s_ready && (rd_idx == 4'd15);
        load      = close && last_fire;
        if (last_fire && !close) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx <= '0;
      ovf_q  <= 1'b0;
      for (int c = 0; c < 16; c++) obuf[c] <= '0;
    end else begin
      if (load) begin
        rd_idx <= '0;
        for (int c = 0; c < 16; c++) obuf[c] <= acc_fin[c] - MID_SCALE;
      end else if (fire) begin
        rd_idx <= rd_idx + 1'b1;
      end
      if (close && !load) ovf_q <= 1'b1;
    end
  end

  assign pdm_clk  = pdm_clk_q;
  assign s_data   = obuf[rd_idx];
  assign s_chan   = rd_idx;
  assign s_last   = s_valid && (rd_idx == 4'd15);
  assign overflow = ovf_q;

endmodule
